machine_log_reader: RTL
=======================

Name: machine_log_reader

Overview:
- Capture side of the vending-machine log path. Accepts one log record per cycle from the machine controller and holds it in a circular on-chip buffer.
- A host or debug port drains the buffer in arrival order through a request/valid read interface.
- Record fields use the same encoding as the log writer:
  - op: 00 buy, 01 charge machine, 10 receive money, 11 change price.
  - status: 0 error, 1 pass.
  - three 4-bit parameters.
- Oldest records are overwritten on overflow, so the newest history is always retained.

Parameters:
- DEPTH, 16, number of record slots; must be a power of two, at least 2.
- PTR_W, 4, log2(DEPTH).
- DROP_W, 8, width of the saturating overwrite counter.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- log_valid  in  1  a record is presented this cycle.
- log_operator  in  2  record op code.
- log_status  in  1  record status bit.
- log_param2  in  4  record parameter 2.
- log_param3  in  4  record parameter 3.
- log_param4  in  4  record parameter 4.
- filter_mask  in  4  bit k=1 keeps records with op==k; 0 discards them.
- clear  in  1  synchronous flush of buffer and flags.
- rd_req  in  1  pop request.
- rd_valid  out  1  rd_* fields hold a popped record.
- rd_operator  out  2  popped op code.
- rd_status  out  1  popped status bit.
- rd_param2  out  4  popped parameter 2.
- rd_param3  out  4  popped parameter 3.
- rd_param4  out  4  popped parameter 4.
- rd_underflow  out  1  one-cycle pulse: rd_req arrived while empty.
- count  out  PTR_W+1  records currently stored, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky: at least one record overwritten since reset or clear.
- drop_count  out  DROP_W  overwritten records, saturates at all-ones.

Behaviour:
- Storage and pointers:
  - Each record is 15 bits: {op, status, p2, p3, p4}.
  - wr_ptr and rd_ptr are PTR_W bits and wrap modulo DEPTH.
  - count is held in a register.
- Reset (async, reset_n=0):
  - wr_ptr, rd_ptr and count clear to 0.
  - rd_valid, rd_underflow, overflow, drop_count and all rd_* fields clear to 0.
  - empty=1, full=0.
  - Memory contents are don't-care.
  - Reset applied mid-operation discards all records immediately.
- Write acceptance:
  - A record is accepted when log_valid=1, filter_mask[log_operator]=1 and clear=0.
  - A filtered record is discarded silently: it does not touch count, overflow or drop_count.
- Read, 1-cycle latency:
  - rd_req=1 with empty=0 at edge N: at edge N+1, rd_valid=1 and rd_* show the record at rd_ptr.
  - In the same cycle rd_ptr increments and count decrements.
  - rd_valid is a single-cycle pulse per pop.
  - rd_* fields hold their last value while rd_valid=0.
- Read while empty:
  - rd_req=1 with empty=1: no pop; rd_valid=0 and rd_underflow=1 for one cycle.
- Write while not full: store at wr_ptr, wr_ptr++, count++.
- Write while full, no pop that cycle:
  - Overwrite the oldest slot: store at wr_ptr, wr_ptr++, rd_ptr++.
  - count stays at DEPTH.
  - overflow is set to 1.
  - drop_count increments, saturating.
- Simultaneous write and pop:
  - The pop is evaluated against the pre-edge state; the popped record is the old rd_ptr entry. count is unchanged.
  - When full, the pop frees a slot, so there is no overwrite and no overflow.
  - When empty, the pop underflows and the write is stored; there is no same-cycle bypass.
- Clear:
  - clear=1 has priority over write and read in the same cycle.
  - Pointers and count go to 0; overflow and drop_count go to 0.
  - rd_valid=0 and rd_underflow=0 next cycle.
  - The record presented in the clear cycle is dropped without being counted.
- Status flags: full and empty are combinational decodes of count.

Test Plan:
- Write {00,1,3,2,9}, then {10,1,5,0,0}; pulse rd_req twice -> rd_valid one cycle after each request, fields {00,1,3,2,9} then {10,1,5,0,0}; count goes 2,1,0; empty=1.
- From reset, pulse rd_req -> rd_underflow=1 for one cycle, rd_valid=0, count=0.
- Write 18 records with p2=0..17 at DEPTH=16 -> count=16, full=1, overflow=1, drop_count=2; sixteen pops return p2=2..17 in order.
- Fill to 16, then assert log_valid and rd_req in the same cycle -> popped p2=0, count=16, overflow=0, drop_count=0.
- filter_mask=4'b1011, write one record with op=10 and one with op=11 -> only the op=11 record is stored; count=1.
- With count=5, assert clear together with log_valid and rd_req -> count=0, empty=1, rd_valid=0; then assert reset_n=0 mid-stream -> all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/machine_log_reader.sv
`default_nettype none
// ============================================================================
//  Module      : machine_log_reader
//  Description : Capture side of the vending-machine log path. Accepts one
//                15-bit log record per cycle into a circular buffer and lets
//                a host drain it, oldest first, through a request/valid port.
//                On overflow the oldest record is overwritten so the newest
//                history is retained; overwrites are counted (saturating).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock, reset_n           : rising-edge clock, async active-low reset
//    log_valid, log_operator, log_status, log_param2..4
//                             : incoming record (op/status/three params)
//    filter_mask              : bit k keeps records with op==k
//    clear                    : synchronous flush of buffer and flags
//    rd_req                   : pop request
//    rd_valid, rd_operator, rd_status, rd_param2..4
//                             : popped record, one cycle after the request
//    rd_underflow             : one-cycle pulse, pop requested while empty
//    count, full, empty       : occupancy
//    overflow, drop_count     : sticky overwrite flag, saturating counter
// ============================================================================
module machine_log_reader #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int DROP_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              log_valid,
  input  logic [1:0]        log_operator,
  input  logic              log_status,
  input  logic [3:0]        log_param2,
  input  logic [3:0]        log_param3,
  input  logic [3:0]        log_param4,
  input  logic [3:0]        filter_mask,
  input  logic              clear,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [1:0]        rd_operator,
  output logic              rd_status,
  output logic [3:0]        rd_param2,
  output logic [3:0]        rd_param3,
  output logic [3:0]        rd_param4,
  output logic              rd_underflow,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  localparam int             REC_W    = 15;
  localparam logic [PTR_W:0] C_FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Record storage; contents are don't-care after reset, so no reset here.
  logic [REC_W-1:0]  mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              rd_valid_q, rd_valid_d;
  logic              underflow_q, underflow_d;
  logic [REC_W-1:0]  rd_rec_q, rd_rec_d;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_en;
  logic              w_pop;
  logic              w_overwrite;
  logic [REC_W-1:0]  w_rec;

  assign w_full  = (count_q == C_FULL_CNT);
  assign w_empty = (count_q == '0);
  assign w_rec   = {log_operator, log_status, log_param2, log_param3, log_param4};

  // clear has priority over both the write and the pop.
  assign w_wr_en = log_valid & filter_mask[log_operator] & ~clear;
  assign w_pop   = rd_req & ~w_empty & ~clear;
  // A pop in the same cycle frees a slot, so only an unaccompanied write
  // into a full buffer displaces the oldest record.
  assign w_overwrite = w_wr_en & w_full & ~w_pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;
    rd_valid_d  = 1'b0;
    underflow_d = 1'b0;
    rd_rec_d    = rd_rec_q;

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else begin
      underflow_d = rd_req & w_empty;

      if (w_pop) begin
        rd_valid_d = 1'b1;
        rd_rec_d   = mem_q[rd_ptr_q];
      end

      if (w_wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (w_pop || w_overwrite) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end

      if (w_wr_en && !w_pop && !w_full) begin
        count_d = count_q + 1'b1;
      end else if (w_pop && !w_wr_en) begin
        count_d = count_q - 1'b1;
      end

      if (w_overwrite) begin
        overflow_d = 1'b1;
        if (drop_q != '1) begin
          drop_d = drop_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q] <= w_rec;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_rec_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
      rd_valid_q  <= rd_valid_d;
      underflow_q <= underflow_d;
      rd_rec_q    <= rd_rec_d;
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_underflow = underflow_q;
  assign {rd_operator, rd_status, rd_param2, rd_param3, rd_param4} = rd_rec_q;
  assign count        = count_q;
  assign full         = w_full;
  assign empty        = w_empty;
  assign overflow     = overflow_q;
  assign drop_count   = drop_q;

endmodule
`default_nettype wire
